// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants and types for the oversampling SPI slave
//
// Purpose: SPI mode encodings ({cpol,cpha}), the frame FSM state type and a
//          helper that maps a mode to its sample edge.
// Ports:   none (package).
// Build:   no configuration macros.

package spi_pkg;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_t;

    // Modes 0 and 3 sample on the rising sclk edge, modes 1 and 2 on falling.
    function automatic logic sample_on_rise(input logic [1:0] mode);
        return ~(mode[1] ^ mode[0]);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchronizer with rise/fall detection
//
// Purpose: brings an asynchronous pin into the clk domain through STAGES
//          flops and compares the result with a one-clk-delayed copy.
// Ports:   clk, rst_n  - clock, asynchronous active-low reset
//          i_async     - asynchronous input pin
//          o_sync      - synchronized level
//          o_rise      - one-clk pulse on a synchronized 0->1 transition
//          o_fall      - one-clk pulse on a synchronized 1->0 transition
// Build:   no configuration macros.

module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_chain;
    logic              r_dly;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= {STAGES{RST_VAL}};
            r_dly   <= RST_VAL;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_async};
            r_dly   <= r_chain[STAGES-1];
        end
    end

    assign o_sync = r_chain[STAGES-1];
    assign o_rise = r_chain[STAGES-1] & ~r_dly;
    assign o_fall = ~r_chain[STAGES-1] & r_dly;

endmodule

// File: rtl/spi_slave_sync.sv
// rtl/spi_slave_sync.sv - single-clock oversampling SPI slave, all four modes
//
// Purpose: receives and transmits DATA_W-bit words over SPI with sclk, cs_n
//          and mosi oversampled in the clk domain; one byte_sync pulse per
//          completed word, frame_err pulse when cs_n rises mid-word.
// Ports:   clk, rst_n     - clock, asynchronous active-low reset
//          sclk,cs_n,mosi - SPI pins from the master (asynchronous)
//          miso           - slave-out data
//          cpol, cpha     - SPI mode, captured when the frame starts
//          byte_sync      - one-clk pulse: data_in holds a new word
//          data_in        - last completed received word
//          data_out       - next word to transmit (stable from byte_sync
//                           until the following shift edge)
//          busy           - frame active
//          frame_err      - one-clk pulse: frame closed with a partial word
// Build:   SPI_LSB_FIRST_EN - defined: LSB-first in both directions;
//                             undefined: MSB-first.

module spi_slave_sync
    import spi_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    input  logic              cpol,
    input  logic              cpha,
    output logic              byte_sync,
    output logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              frame_err
);

    localparam int              CNT_W  = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DATA_W - 1);

    logic w_sclk_sync, w_sclk_rise, w_sclk_fall;
    logic w_cs_sync, w_cs_rise, w_cs_fall;
    logic w_mosi;
    logic w_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (sclk),
        .o_sync  (w_sclk_sync),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (cs_n),
        .o_sync  (w_cs_sync),
        .o_rise  (w_cs_rise),
        .o_fall  (w_cs_fall)
    );

    // Same depth as the sclk chain so mosi stays aligned with its edge.
    logic [SYNC_STAGES-1:0] r_mosi_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mosi_sync <= '0;
        end else begin
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
        end
    end

    assign w_mosi   = r_mosi_sync[SYNC_STAGES-1];
    assign w_unused = w_sclk_sync ^ w_cs_rise;

    spi_state_t        r_state, w_state_nxt;
    logic              r_cpol, r_cpha;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic              r_pend_load;
    logic [DATA_W-1:0] r_rx_sh, r_tx_sh;
    logic [DATA_W-1:0] r_data_in;
    logic              r_byte_sync, r_frame_err, r_busy;

    logic              w_sample_rise, w_sample_edge, w_shift_edge;
    logic              w_start, w_act, w_close, w_sample, w_shift, w_done, w_abort;
    logic [DATA_W-1:0] w_rx_nxt, w_tx_shifted;

    // Edge selection uses the mode captured at frame start, not the live pins.
    assign w_sample_rise = sample_on_rise({r_cpol, r_cpha});
    assign w_sample_edge = w_sample_rise ? w_sclk_rise : w_sclk_fall;
    assign w_shift_edge  = w_sample_rise ? w_sclk_fall : w_sclk_rise;

`ifdef SPI_LSB_FIRST_EN
    assign w_rx_nxt     = {w_mosi, r_rx_sh[DATA_W-1:1]};
    assign w_tx_shifted = {1'b0, r_tx_sh[DATA_W-1:1]};
    assign miso         = r_tx_sh[0];
`else
    assign w_rx_nxt     = {r_rx_sh[DATA_W-2:0], w_mosi};
    assign w_tx_shifted = {r_tx_sh[DATA_W-2:0], 1'b0};
    assign miso         = r_tx_sh[DATA_W-1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_cs_fall) w_state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (w_cs_sync) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // sclk edges only count while ACTIVE, so edges in IDLE or in the
    // cs_n-fall clk are dropped without extra gating.
    always_comb begin
        w_start  = (r_state == ST_IDLE) && w_cs_fall;
        w_act    = (r_state == ST_ACTIVE);
        w_close  = w_act && w_cs_sync;
        w_sample = w_act && w_sample_edge;
        w_shift  = w_act && w_shift_edge;
        w_done   = w_sample && (r_bit_cnt == C_LAST);
        w_abort  = w_close && !w_done && (r_bit_cnt != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cpol      <= 1'b0;
            r_cpha      <= 1'b0;
            r_bit_cnt   <= '0;
            r_pend_load <= 1'b0;
            r_rx_sh     <= '0;
            r_tx_sh     <= '0;
            r_data_in   <= '0;
            r_byte_sync <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_byte_sync <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_start) begin
                r_cpol    <= cpol;
                r_cpha    <= cpha;
                r_bit_cnt <= '0;
                r_busy    <= 1'b1;
                if (!cpha) begin
                    r_tx_sh     <= data_out;
                    r_pend_load <= 1'b0;
                end else begin
                    r_pend_load <= 1'b1;
                end
            end else if (w_act) begin
                if (w_sample) begin
                    r_rx_sh <= w_rx_nxt;
                    if (w_done) begin
                        r_data_in   <= w_rx_nxt;
                        r_byte_sync <= 1'b1;
                        r_bit_cnt   <= '0;
                        r_pend_load <= 1'b1;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                if (w_shift) begin
                    if (r_pend_load) begin
                        r_tx_sh     <= data_out;
                        r_pend_load <= 1'b0;
                    end else begin
                        r_tx_sh <= w_tx_shifted;
                    end
                end
                // A word completing in the closing clk still reports
                // byte_sync above; the close only clears frame state.
                if (w_close) begin
                    r_frame_err <= w_abort;
                    r_bit_cnt   <= '0;
                    r_pend_load <= 1'b0;
                    r_busy      <= 1'b0;
                    r_tx_sh     <= '0;
                    r_rx_sh     <= '0;
                end
            end
        end
    end

    assign byte_sync = r_byte_sync;
    assign data_in   = r_data_in;
    assign busy      = r_busy;
    assign frame_err = r_frame_err;

endmodule
